// File: rtl/integrate_if.sv
// integrate_if
//   Groups the operator-facing signals of the integrate accumulator processor.
//   The master side (operator/bench) drives enter and Nin.
//   The slave side (processor) drives the status and debug outputs.
//
//   enter       operator strobe; qualifies Nin while the processor waits in INPUT
//   Nin[7:0]    operand entered by the operator
//   halt        high while the processor sits in HALT
//   Nout[7:0]   live copy of accumulator A
//   IR75out     opcode field IR[7:5] of the current instruction
//   StateNoout  controller state number
interface integrate_if;
  logic       enter;
  logic [7:0] Nin;
  logic       halt;
  logic [7:0] Nout;
  logic [2:0] IR75out;
  logic [3:0] StateNoout;

  modport master (
    output enter, Nin,
    input  halt, Nout, IR75out, StateNoout
  );

  modport slave (
    input  enter, Nin,
    output halt, Nout, IR75out, StateNoout
  );
endinterface

// File: rtl/integrate.sv
// integrate
//   Small 8-bit accumulator microprocessor.
//   It contains a controller FSM, a datapath (A, PC, IR) and a 32x8 RAM holding a
//   fixed program. The program reads N, computes 1+2+...+N modulo 256, shows the
//   result on Nout and halts.
//
//   Ports:
//     clock   rising-edge clock
//     reset   synchronous, active-high; restarts the FSM and reloads the RAM image
//     bus     integrate_if.slave: enter/Nin in; halt, Nout, IR75out, StateNoout out
//
//   Optional build macro: INTEGRATE_ENTER_EDGE_EN
//     Defined:   INPUT loads Nin only on a 0->1 transition of enter. A registered
//                copy of enter is kept for this, and reset clears it.
//     Undefined: INPUT loads Nin whenever enter is high at the clock edge.
module integrate (
  input logic        clock,
  input logic        reset,
  integrate_if.slave bus
);

  typedef enum logic [3:0] {
    START  = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LOAD   = 4'd8,
    STORE  = 4'd9,
    ADD    = 4'd10,
    SUB    = 4'd11,
    INPUT  = 4'd12,
    JZ     = 4'd13,
    JPOS   = 4'd14,
    HALT   = 4'd15
  } state_t;

  state_t     state;
  logic [7:0] a;
  logic [4:0] pc;
  logic [7:0] ir;
  logic [7:0] mem [32];

  logic [7:0] operand;
  logic       inputAccept;

  // Program image restored into RAM on every reset. Unlisted locations are 0.
  function automatic logic [7:0] progWord(input logic [4:0] addr);
    logic [7:0] w;
    case (addr)
      5'd0:    w = 8'h80;  // IN
      5'd1:    w = 8'h3E;  // STORE 30
      5'd2:    w = 8'h1C;  // LOAD 28
      5'd3:    w = 8'h5E;  // ADD 30
      5'd4:    w = 8'h3C;  // STORE 28
      5'd5:    w = 8'h1E;  // LOAD 30
      5'd6:    w = 8'h7D;  // SUB 29
      5'd7:    w = 8'h3E;  // STORE 30
      5'd8:    w = 8'hC2;  // JPOS 2
      5'd9:    w = 8'h1C;  // LOAD 28
      5'd10:   w = 8'hE0;  // HALT
      5'd29:   w = 8'h01;  // constant 1
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  // Operand read is combinational from the address field of IR.
  assign operand = mem[ir[4:0]];

`ifdef INTEGRATE_ENTER_EDGE_EN
  logic enterPrev;

  // Remember enter from the previous edge so INPUT can detect a fresh 0->1 strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      enterPrev <= 1'b0;
    end else begin
      enterPrev <= bus.enter;
    end
  end

  assign inputAccept = bus.enter && !enterPrev;
`else
  assign inputAccept = bus.enter;
`endif

  // Controller and datapath in one clocked block: each state performs its
  // register transfer and picks the next state. Reset also reloads the RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= START;
      pc    <= 5'd0;
      ir    <= 8'h00;
      a     <= 8'h00;
      for (int i = 0; i < 32; i++) begin
        mem[i] <= progWord(5'(i));
      end
    end else begin
      case (state)
        START: begin
          state <= FETCH;
        end
        FETCH: begin
          ir    <= mem[pc];
          pc    <= pc + 5'd1;
          state <= DECODE;
        end
        DECODE: begin
          // Execute states are numbered 8 + opcode.
          state <= state_t'({1'b1, ir[7:5]});
        end
        LOAD: begin
          a     <= operand;
          state <= FETCH;
        end
        STORE: begin
          mem[ir[4:0]] <= a;
          state        <= FETCH;
        end
        ADD: begin
          a     <= a + operand;
          state <= FETCH;
        end
        SUB: begin
          a     <= a - operand;
          state <= FETCH;
        end
        INPUT: begin
          if (inputAccept) begin
            a     <= bus.Nin;
            state <= FETCH;
          end
        end
        JZ: begin
          if (a == 8'h00) begin
            pc <= ir[4:0];
          end
          state <= FETCH;
        end
        JPOS: begin
          // Strictly positive means sign bit clear and not zero.
          if (!a[7] && (a != 8'h00)) begin
            pc <= ir[4:0];
          end
          state <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= START;
        end
      endcase
    end
  end

  assign bus.halt       = (state == HALT);
  assign bus.Nout       = a;
  assign bus.IR75out    = ir[7:5];
  assign bus.StateNoout = state;

endmodule

// File: tb/tb_integrate.sv
// tb_integrate
//   Directed self-checking bench for the integrate accumulator processor.
//   It runs the summing program for several N, resets mid-run, pokes inputs while
//   the processor is halted and, when INTEGRATE_ENTER_EDGE_EN is defined, checks
//   that enter must be strobed 0->1 before INPUT loads.
module tb_integrate;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  integrate_if bus ();

  integrate dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold reset for two edges, then release it.
  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a given state number; the final compare records a timeout.
  task automatic waitState(input string tag, input logic [3:0] target, input int budget);
    for (int i = 0; i < budget && bus.StateNoout != target; i++) tick();
    checkOutput(tag, bus.StateNoout, target);
  endtask

  // Wait (bounded) for halt and check the final visible outputs.
  task automatic runToHalt(input string tag, input logic [7:0] expOut);
    for (int i = 0; i < 3000 && !bus.halt; i++) tick();
    checkOutput({tag, " halt"}, bus.halt, 1);
    checkOutput({tag, " Nout"}, bus.Nout, expOut);
    checkOutput({tag, " IR75out"}, bus.IR75out, 3'b111);
    checkOutput({tag, " state"}, bus.StateNoout, 15);
  endtask

  // Full run from reset: enter N with a single enter strobe and check the result.
  task automatic applyStimulus(input string tag, input logic [7:0] n, input logic [7:0] expOut);
    bus.enter = 1'b0;
    bus.Nin   = n;
    doReset();
    waitState({tag, " reach INPUT"}, 4'd12, 20);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    checkOutput({tag, " A loaded"}, bus.Nout, n);
    runToHalt(tag, expOut);
  endtask

  initial begin
    logic [7:0] heldOut;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.enter = 1'b0;
    bus.Nin   = 8'd9;

    // Reset values and the start-up state walk.
    reset = 1'b1;
    tick();
    checkOutput("reset state", bus.StateNoout, 0);
    checkOutput("reset Nout", bus.Nout, 0);
    checkOutput("reset halt", bus.halt, 0);
    checkOutput("reset IR75out", bus.IR75out, 0);
    tick();
    reset = 1'b0;
    checkOutput("release state0", bus.StateNoout, 0);
    tick();
    checkOutput("release state1", bus.StateNoout, 1);
    tick();
    checkOutput("release state2", bus.StateNoout, 2);
    tick();
    checkOutput("release state12", bus.StateNoout, 12);

    // INPUT waits while enter is low.
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("wait in INPUT", bus.StateNoout, 12);
      checkOutput("wait Nout", bus.Nout, 0);
    end
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    checkOutput("N=9 A loaded", bus.Nout, 9);
    checkOutput("N=9 after INPUT", bus.StateNoout, 1);
    runToHalt("N=9", 8'd45);

    // Boundary values of N.
    applyStimulus("N=1", 8'd1, 8'd1);
    applyStimulus("N=22", 8'd22, 8'd253);
    applyStimulus("N=0", 8'd0, 8'd0);

    // Reset in the middle of the loop, then a clean rerun.
    bus.enter = 1'b0;
    bus.Nin   = 8'd22;
    doReset();
    waitState("midrun INPUT", 4'd12, 20);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    for (int k = 0; k < 3; k++) waitState("midrun ADD", 4'd10, 50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrun reset state", bus.StateNoout, 0);
    checkOutput("midrun reset Nout", bus.Nout, 0);
    checkOutput("midrun reset halt", bus.halt, 0);
    applyStimulus("N=5", 8'd5, 8'd15);

    // Inputs are ignored in HALT.
    heldOut = bus.Nout;
    for (int i = 0; i < 20; i++) begin
      bus.enter = ~bus.enter;
      bus.Nin   = 8'($urandom_range(0, 255));
      tick();
      checkOutput("halt hold halt", bus.halt, 1);
      checkOutput("halt hold Nout", bus.Nout, heldOut);
      checkOutput("halt hold state", bus.StateNoout, 15);
    end
    applyStimulus("after halt N=3", 8'd3, 8'd6);

`ifdef INTEGRATE_ENTER_EDGE_EN
    // enter held high through reset must not load until it falls and rises.
    bus.enter = 1'b1;
    bus.Nin   = 8'd9;
    doReset();
    waitState("edge INPUT", 4'd12, 20);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("edge held state", bus.StateNoout, 12);
      checkOutput("edge held Nout", bus.Nout, 0);
    end
    bus.enter = 1'b0;
    tick();
    checkOutput("edge low state", bus.StateNoout, 12);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    checkOutput("edge loaded", bus.Nout, 9);
    runToHalt("edge N=9", 8'd45);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/integrate.md
Name: integrate

Overview:
- Small 8-bit accumulator microprocessor: controller FSM, datapath (A, PC, IR) and a 32x8 RAM preloaded with a fixed program.
- The program reads N from Nin when enter is asserted, computes 1+2+…+N modulo 256, drives the result on Nout, then halts.
- Top-level integration block; IR75out and StateNoout exist for debug and verification.

Parameters:
- None. Widths are fixed: data 8 bits, address 5 bits, memory depth 32.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-high reset
- enter  input  1  operator strobe; qualifies Nin during the INPUT state
- Nin  input  8  operand input
- halt  output  1  high while the FSM is in the HALT state
- Nout  output  8  continuously equals accumulator A
- IR75out  output  3  IR[7:5], the current opcode
- StateNoout  output  4  current FSM state number

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates occur on the rising edge of clock.
- Reset (any time, including mid-instruction or in HALT), at the next edge:
  - state=START(0), PC=0, IR=0, A=0, so Nout=0, halt=0, IR75out=0.
  - RAM reloaded with the program image below.
- Instruction format: IR[7:5] opcode, IR[4:0] address.
- States (StateNoout value):
  - START=0: goes to FETCH.
  - FETCH=1: IR<=M[PC], PC<=PC+1 (5-bit wrap, 31->0); next DECODE.
  - DECODE=2: next state = 8+opcode.
  - LOAD=8 (000): A<=M[addr].
  - STORE=9 (001): M[addr]<=A.
  - ADD=10 (010): A<=A+M[addr], mod 256.
  - SUB=11 (011): A<=A-M[addr], mod 256.
  - INPUT=12 (100): stays in INPUT while enter=0. When enter=1 at the edge, A<=Nin.
  - JZ=13 (101): if A==0, PC<=addr.
  - JPOS=14 (110): if A[7]==0 and A!=0, PC<=addr.
  - HALT=15 (111): halt=1; remains in HALT until reset.
  - All execute states other than INPUT and HALT return to FETCH after one cycle. States 3–7 are unused and go to START.
- Latency: 3 cycles per instruction, except INPUT (3 + wait cycles) and HALT (terminal).
- RAM has a synchronous write (STORE) and a combinational read.
- Program image (address: word). All other locations are 0.
  - 0: 8'h80 IN
  - 1: 8'h3E STORE 30
  - 2: 8'h1C LOAD 28
  - 3: 8'h5E ADD 30
  - 4: 8'h3C STORE 28
  - 5: 8'h1E LOAD 30
  - 6: 8'h7D SUB 29
  - 7: 8'h3E STORE 30
  - 8: 8'hC2 JPOS 2
  - 9: 8'h1C LOAD 28
  - 10: 8'hE0 HALT
  - 28: 8'h00 (sum)
  - 29: 8'h01 (constant 1)
  - 30: 8'h00 (n)
- Final A is sum(1..N) mod 256.
  - N=0: loop runs once, n becomes 255 (negative), exits with A=0.
  - N in 1..22: exact result.
  - Larger N: result is the modulo-256 value the program produces. The loop exits when n-1 is zero or has bit 7 set.
- Nout and IR75out are combinational from registers. StateNoout is the state register.

Optional Feature:
- Macro INTEGRATE_ENTER_EDGE_EN.
- Defined: INPUT accepts Nin only on a rising edge of enter, meaning enter was 0 on the previous clock edge and is 1 now. A registered copy of enter is kept, cleared by reset. enter held high on entry to INPUT does not load until it falls and rises again.
- Undefined: INPUT is level-sensitive, as specified in Behaviour.

Test Plan:
- Reset asserted for 2 cycles, then released -> StateNoout=0, Nout=0, halt=0, IR75out=0 during reset; StateNoout sequence 0,1,2,12 after release.
- Nin=9 with enter=0 for 10 cycles, then enter=1 -> StateNoout stays 12 while enter=0; A loads on the enter=1 edge; eventually halt=1, Nout=45 (8'h2D), IR75out=3'b111, StateNoout=15.
- Nin=1, Nin=22, Nin=0, each run from reset -> final Nout=1, 253, 0 respectively; halt=1 in each case.
- Assert reset mid-loop (e.g. while StateNoout=10), then rerun with Nin=5 -> state returns to 0, RAM reloaded (sum cleared), final Nout=15.
- In HALT, toggle enter and change Nin for 20 cycles -> halt stays 1, Nout unchanged, StateNoout=15; reset then restarts normally.
- With INTEGRATE_ENTER_EDGE_EN defined, enter held at 1 through reset and into INPUT -> no load until enter goes 0 then 1; then Nin=9 yields Nout=45.
